// File: rtl/sram_req_master_if.sv
// Request/response channels and single-port SRAM macro pins for sram_req_master.
// master: controller view; slave: the requester and memory surrounding it.
interface sram_req_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] sram_adr;
  logic              sram_cen;
  logic              sram_wen;
  logic [STRB_W-1:0] sram_wstrb;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, sram_q,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
           sram_adr, sram_cen, sram_wen, sram_wstrb, sram_d
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, sram_q,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
           sram_adr, sram_cen, sram_wen, sram_wstrb, sram_d
  );
endinterface

// File: rtl/sram_req_master.sv
// Issues valid/ready requests to a single-port SRAM as registered commands and
// returns in-order responses through a credit-limited response FIFO.
module sram_req_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  sram_req_master_if.master   bus
);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  credits_q, credits_d;
  logic              ready_q, ready_d;

  logic              s1_cen_q, s1_cen_d;
  logic              s1_wen_q, s1_wen_d;
  logic [ADDR_W-1:0] s1_adr_q, s1_adr_d;
  logic [STRB_W-1:0] s1_wstrb_q, s1_wstrb_d;
  logic [DATA_W-1:0] s1_d_q, s1_d_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_write_q, s2_write_d;

  logic [DATA_W:0]   mem_q [RSP_DEPTH];
  logic [DATA_W:0]   mem_d [RSP_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  logic              req_fire, rsp_fire;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W:0]   head;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign req_fire   = bus.req_valid & ready_q;
  assign rsp_fire   = ~fifo_empty & bus.rsp_ready;
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign push_data  = s2_write_q ? '0 : bus.sram_q;

  always_comb begin
    credits_d  = credits_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    // Ready is registered from next-state credits so it has no path from rsp_ready.
    ready_d    = (credits_d != CNT_W'(RSP_DEPTH));

    s1_cen_d   = req_fire;
    s1_wen_d   = req_fire & bus.req_write;
    s1_adr_d   = req_fire ? bus.req_addr : '0;
    s1_wstrb_d = (req_fire & bus.req_write) ? bus.req_wstrb : '0;
    s1_d_d     = (req_fire & bus.req_write) ? bus.req_wdata : '0;

    s2_valid_d = s1_cen_q;
    s2_write_d = s1_wen_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (s2_valid_q) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {s2_write_q, push_data};
      wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
    end
    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      credits_q  <= '0;
      ready_q    <= 1'b0;
      s1_cen_q   <= 1'b0;
      s1_wen_q   <= 1'b0;
      s1_adr_q   <= '0;
      s1_wstrb_q <= '0;
      s1_d_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_write_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      credits_q  <= credits_d;
      ready_q    <= ready_d;
      s1_cen_q   <= s1_cen_d;
      s1_wen_q   <= s1_wen_d;
      s1_adr_q   <= s1_adr_d;
      s1_wstrb_q <= s1_wstrb_d;
      s1_d_q     <= s1_d_d;
      s2_valid_q <= s2_valid_d;
      s2_write_q <= s2_write_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(s2_valid_q && fifo_full && !rsp_fire));

  assign bus.req_ready  = ready_q;
  assign bus.sram_cen   = s1_cen_q;
  assign bus.sram_wen   = s1_wen_q;
  assign bus.sram_adr   = s1_adr_q;
  assign bus.sram_wstrb = s1_wstrb_q;
  assign bus.sram_d     = s1_d_q;
  assign bus.rsp_valid  = ~fifo_empty;
  assign bus.rsp_write  = ~fifo_empty & head[DATA_W];
  assign bus.rsp_rdata  = fifo_empty ? '0 : head[DATA_W-1:0];
endmodule

// File: doc/sram_req_master.md
Name: sram_req_master

Overview:
- Initiator-side controller for the single-port SRAM macro interface: adr, cen, wen, wstrb, d, q.
- Accepts read/write requests on a valid/ready channel and issues them to the SRAM as registered commands.
- Returns one in-order response per request on a valid/ready channel, through a credit-limited response FIFO.
- Replaces ad-hoc stimulus as the standard way cores and DMA talk to sram_model-class memories.

Parameters:
ADDR_W, 8, SRAM word-address width
DATA_W, 32, data width; multiple of 8
STRB_W, DATA_W/8, byte-strobe width
RSP_DEPTH, 4, response FIFO entries and max outstanding requests; power of 2, >=4

Ports:
clock  input  1  clock
reset  input  1  reset: synchronous, active-high; clock is clock
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&ready
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_wstrb  input  STRB_W  byte enables (bit i -> byte i)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when valid&ready
rsp_write  output  1  echo of req_write
rsp_rdata  output  DATA_W  read data; 0 for writes
sram_adr  output  ADDR_W  SRAM address
sram_cen  output  1  SRAM access enable, active-high
sram_wen  output  1  SRAM write enable, active-high
sram_wstrb  output  STRB_W  SRAM byte enables
sram_d  output  DATA_W  SRAM write data
sram_q  input  DATA_W  SRAM read data; valid the cycle after an access is sampled

Behaviour:
- Reset: every output is 0 in the cycle after a reset edge, including req_ready, rsp_valid, rsp_* and all sram_*.
- Reset discards the credit count, S1, S2 and the FIFO. No stale response appears after release.
- req_ready is 1 in the first cycle after reset deasserts.
- Credit counter, width log2(RSP_DEPTH)+1:
  - +1 on req fire; -1 on rsp fire; both in the same cycle -> unchanged.
  - req_ready = (credits != RSP_DEPTH). It is a function of registered state only; there is no combinational path from rsp_ready or req_valid.
- Stage S1, command register:
  - On req fire at edge E, during the next cycle: sram_cen=1, sram_adr=req_addr, sram_wen=req_write.
  - Writes: sram_wstrb=req_wstrb, sram_d=req_wdata.
  - Reads: sram_wstrb=0, sram_d=0.
  - With no fire: sram_cen=0 and all other sram_* are 0.
  - A write with wstrb=0 is still issued (cen=1) and still gets a response.
- Stage S2, one cycle after S1:
  - Holds {valid, write}. If valid, at the end of the S2 cycle push {write, write ? 0 : sram_q} into the FIFO.
- FIFO:
  - RSP_DEPTH entries with wrap-around read/write pointers.
  - rsp_valid = not empty; rsp_* are driven from the head entry.
  - Push and pop in the same cycle are both performed.
  - Overflow cannot occur because of the credit limit; overflow is an assertion failure in simulation.
- Latency: req fire at edge E -> sram_cen high in cycle E+1 -> q captured at end of E+2 -> rsp_valid from E+3, FIFO empty and no backpressure.
- Throughput: one request per cycle sustained while rsp_ready=1. RSP_DEPTH=4 covers the 3-cycle loop.
- Ordering: strictly in order. Read-after-write to the same address in back-to-back cycles returns the new data, because the SRAM is single-port and sequential.
- Response stability: rsp_rdata and rsp_write are held stable while rsp_valid=1 and rsp_ready=0.
- Inputs are ignored when req_ready=0.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF at edge E -> cycle E+1: sram_cen=1, sram_wen=1, sram_adr=0x10, sram_d=0xDEADBEEF. From E+3: rsp_valid=1, rsp_write=1, rsp_rdata=0.
- Read addr 0x10 immediately following the write (back-to-back) -> cycle of read command: sram_cen=1, sram_wen=0, sram_wstrb=0. Response: rsp_write=0, rsp_rdata=0xDEADBEEF.
- Write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5, then read the same addr -> rsp_rdata=0x11BB33DD.
- Hold rsp_ready=0 with req_valid=1 every cycle -> exactly 4 requests accepted, then req_ready=0. The FIFO head is held stable. Raise rsp_ready -> 4 in-order responses on consecutive cycles. req_ready returns to 1 the cycle after the first pop.
- rsp_ready=1 with 16 consecutive reads, addrs 0..15 -> 16 accepts in 16 cycles, 16 responses on 16 consecutive cycles, rdata matching a reference memory.
- Assert reset for 1 cycle with 3 requests outstanding -> next cycle all outputs are 0. After release: req_ready=1, no rsp_valid until a new request is issued, and credits allow 4 new accepts.
